// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM encoding, multiplier iteration count.
package exec_pkg;
    localparam int EXEC_WIDTH = 16;
    localparam int MUL_ITERS  = EXEC_WIDTH;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Single-cycle ops that produce a writeback the cycle after accept.
    function automatic logic is_simple_op(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction
endpackage

// File: rtl/exec_if.sv
// Issue/writeback bundle between issuer, execute stage and register file write port.
interface exec_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] dst_addr;
    logic [WIDTH-1:0]  ra_data;
    logic [WIDTH-1:0]  rb_data;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              we;
    logic              flag_z;
    logic              flag_c;
    logic              flag_n;

    modport master (
        output in_valid, opcode, dst_addr, ra_data, rb_data,
        input  in_ready, wr_data, wr_addr, we, flag_z, flag_c, flag_n
    );

    modport slave (
        input  in_valid, opcode, dst_addr, ra_data, rb_data,
        output in_ready, wr_data, wr_addr, we, flag_z, flag_c, flag_n
    );
endinterface

// File: rtl/exec_unit_shift_add_mul16.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of A*B.
// done_o is asserted during the final iteration with prod_o already holding the full result.
module shift_add_mul16
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);
    localparam int CNT_W = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_LAST);
    assign prod_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU with registered writeback and flags.
// Build option EXEC_MUL_EN adds opcode 9 via the iterative multiplier and a MUL stall state.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic clk,
    input  logic rst,
    exec_if.slave bus
);
    logic              accept;
    logic [WIDTH:0]    res_ext;
    logic [WIDTH:0]    shr_ext;
    logic [3:0]        amt;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;

    logic [WIDTH-1:0]  wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              we_q;
    logic              z_q, c_q, n_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign amt     = bus.rb_data[3:0];
    assign alu_res = res_ext[WIDTH-1:0];
    assign alu_c   = res_ext[WIDTH];

    // Bit WIDTH of res_ext carries the carry, borrow, or last shifted-out bit.
    always_comb begin
        res_ext = '0;
        shr_ext = '0;
        case (bus.opcode)
            OP_ADD: res_ext = {1'b0, bus.ra_data} + {1'b0, bus.rb_data};
            OP_SUB: res_ext = {1'b0, bus.ra_data} - {1'b0, bus.rb_data};
            OP_AND: res_ext = {1'b0, bus.ra_data & bus.rb_data};
            OP_OR:  res_ext = {1'b0, bus.ra_data | bus.rb_data};
            OP_XOR: res_ext = {1'b0, bus.ra_data ^ bus.rb_data};
            OP_NOT: res_ext = {1'b0, ~bus.ra_data};
            OP_SHL: res_ext = {1'b0, bus.ra_data} << amt;
            OP_SHR: begin
                shr_ext = {bus.ra_data, 1'b0} >> amt;
                res_ext = {shr_ext[0], shr_ext[WIDTH:1]};
            end
            OP_MOV: res_ext = {1'b0, bus.rb_data};
            default: res_ext = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    state_t            state_q;
    logic              in_ready_q;
    logic [ADDR_W-1:0] mul_dst_q;
    logic              mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0]  mul_prod;

    assign mul_start    = accept && (state_q == ST_IDLE) && (bus.opcode == OP_MUL) && !mul_busy;
    assign bus.in_ready = in_ready_q;

    shift_add_mul16 #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (bus.ra_data),
        .b_i     (bus.rb_data),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            mul_dst_q  <= '0;
            we_q       <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            n_q        <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_simple_op(bus.opcode)) begin
                        we_q      <= 1'b1;
                        wr_data_q <= alu_res;
                        wr_addr_q <= bus.dst_addr;
                        z_q       <= (alu_res == '0);
                        c_q       <= alu_c;
                        n_q       <= alu_res[WIDTH-1];
                    end else if (mul_start) begin
                        state_q    <= ST_MUL;
                        in_ready_q <= 1'b0;
                        mul_dst_q  <= bus.dst_addr;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        we_q       <= 1'b1;
                        wr_data_q  <= mul_prod;
                        wr_addr_q  <= mul_dst_q;
                        z_q        <= (mul_prod == '0);
                        c_q        <= 1'b0;
                        n_q        <= mul_prod[WIDTH-1];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign bus.in_ready = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (accept && is_simple_op(bus.opcode)) begin
                we_q      <= 1'b1;
                wr_data_q <= alu_res;
                wr_addr_q <= bus.dst_addr;
                z_q       <= (alu_res == '0);
                c_q       <= alu_c;
                n_q       <= alu_res[WIDTH-1];
            end
        end
    end
`endif

    assign bus.we      = we_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.flag_z  = z_q;
    assign bus.flag_c  = c_q;
    assign bus.flag_n  = n_q;
endmodule
